rf_cmd_initiator: RTL and testbench
===================================

Name: rf_cmd_initiator

Overview:
Command-driven initiator for an 8-entry x 8-bit, 2-read/1-write register file. The register file performs combinational reads, writes on the clock edge, forwards same-cycle writes to reads, and hardwires r0 to zero.
The block accepts register-register and immediate ALU commands over a val/rdy interface and drives the RF read and write ports. It returns each result on a val/rdy response port.
It is a two-stage pipeline, X (read/execute) then W (writeback/response), used as the RF's front end in datapath tests and small sequencers.

Parameters:
DATA_W, 8, register width; only the default is supported.
ADDR_W, 3, register address width; only the default is supported (8 entries).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
cmd_val  in  1  command valid.
cmd_rdy  out  1  command ready.
cmd_op  in  2  0=ADD, 1=SUB, 2=ADDI, 3=LI.
cmd_rd  in  3  destination register.
cmd_rs1  in  3  source register 1.
cmd_rs2  in  3  source register 2.
cmd_imm  in  8  immediate.
rf_read_addr0  out  3  RF read port 0 address.
rf_read_data0  in  8  RF read port 0 data.
rf_read_addr1  out  3  RF read port 1 address.
rf_read_data1  in  8  RF read port 1 data.
rf_write_en  out  1  RF write enable.
rf_write_addr  out  3  RF write address.
rf_write_data  out  8  RF write data.
resp_val  out  1  response valid.
resp_rdy  in  1  response ready.
resp_data  out  8  computed result.

Behaviour:
- Reset (reset==0, asynchronous) clears both stage-valid bits and all stage registers. Every output is 0, except cmd_rdy, which is 1 (0 with the optional feature until init completes).
- Handshakes fire on val&&rdy at the rising edge.
- X stage:
  - Latches op/rd/rs1/rs2/imm on cmd fire.
  - Drives rf_read_addr0=rs1 and rf_read_addr1=rs2 while X is valid; both are 0 when X is empty.
- Advance: X moves to W when W is empty or W is firing.
  - On advance, W captures rd and the result, computed from the same-cycle rf_read_data0/1.
- Results, all mod 256:
  - ADD: d0+d1.
  - SUB: d0-d1.
  - ADDI: d0+imm.
  - LI: imm; read ports are still driven but their data is ignored.
- cmd_rdy = !x_val || x_advance. A new command may be accepted in the same cycle X advances.
- W stage outputs:
  - resp_val=w_val; resp_data=w_result.
  - rf_write_en = w_val && resp_rdy; the register write and the response fire in the same cycle.
  - rf_write_addr=w_rd and rf_write_data=w_result while W is valid, else 0.
- Latency: a command accepted at edge N appears on resp_val during cycle N+2 when there is no backpressure. Throughput is 1 command per cycle.
- Dependency (X reads W's rd):
  - If W fires, the RF's same-cycle forwarding supplies the new value.
  - If W is stalled, X does not advance and re-samples when W fires.
  - No internal bypass; RF forwarding is a required property of the attached RF.
- rd=0: the write is issued; the RF discards it. resp_data still reports the computed value.
- Backpressure: resp_rdy=0 holds W and suppresses rf_write_en. X then stalls if valid, and cmd_rdy drops.
- Reset mid-operation drops all in-flight commands. No partial write occurs after reset asserts.

Optional Feature:
RF_CMD_INIT_EN
- With the macro defined, an INIT state follows reset.
  - A 3-bit counter walks addresses 1..7, one per cycle, with rf_write_en=1 and rf_write_data=0.
  - cmd_rdy=0 and resp_val=0 throughout; resp_rdy is ignored during INIT.
  - After address 7, the block enters RUN.
  - Reset during INIT restarts at address 1.
- Without it, the block starts in RUN immediately after reset.

Decomposition:
- Package rf_cmd_pkg: op enum (OP_ADD, OP_SUB, OP_ADDI, OP_LI), DATA_W/ADDR_W constants, NREGS=8.
- One combinational sub-module, rf_cmd_alu (op, d0, d1, imm -> result).
- Pipeline registers, stall logic and the init FSM stay in the top module.

Test Plan:
- LI r1,0xab with resp_rdy=1 -> in cycle N+2: resp_val=1, resp_data=0xab, rf_write_en=1, addr=1, data=0xab.
- LI r1,0x23 then ADDI r2,r1,0x22 back-to-back -> responses 0x23 then 0x45 on consecutive cycles, via RF forwarding.
- r1=0x01, r2=0x02; SUB r3,r1,r2 -> 0xff. Then ADD r4,r3,r2 -> 0x01 (wrap).
- LI r0,0x55 then ADD r1,r0,r0 -> responses 0x55 and 0x00; a later read of r1 returns 0x00.
- Issue 3 commands with resp_rdy=0 for 4 cycles -> cmd_rdy=0 after 2 are accepted, rf_write_en=0, W held. Release -> in-order responses and writes, one per cycle.
- Reset asserted with X and W full -> resp_val and rf_write_en drop immediately. With RF_CMD_INIT_EN, release gives 7 init writes (addresses 1..7, data 0), then cmd_rdy=1.

Source files
------------

// File: rtl/rf_cmd_pkg.sv
// Shared types and constants for the register-file command initiator.
package rf_cmd_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDI = 2'd2,
    OP_LI   = 2'd3
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] result;
  } wb_t;

endpackage

// File: rtl/rf_cmd_initiator_if.sv
// Command, register-file and response signals of the initiator; master is the initiator side.
interface rf_cmd_initiator_if;

  logic                          cmd_val;
  logic                          cmd_rdy;
  logic [1:0]                    cmd_op;
  logic [rf_cmd_pkg::ADDR_W-1:0] cmd_rd;
  logic [rf_cmd_pkg::ADDR_W-1:0] cmd_rs1;
  logic [rf_cmd_pkg::ADDR_W-1:0] cmd_rs2;
  logic [rf_cmd_pkg::DATA_W-1:0] cmd_imm;

  logic [rf_cmd_pkg::ADDR_W-1:0] rf_read_addr0;
  logic [rf_cmd_pkg::DATA_W-1:0] rf_read_data0;
  logic [rf_cmd_pkg::ADDR_W-1:0] rf_read_addr1;
  logic [rf_cmd_pkg::DATA_W-1:0] rf_read_data1;
  logic                          rf_write_en;
  logic [rf_cmd_pkg::ADDR_W-1:0] rf_write_addr;
  logic [rf_cmd_pkg::DATA_W-1:0] rf_write_data;

  logic                          resp_val;
  logic                          resp_rdy;
  logic [rf_cmd_pkg::DATA_W-1:0] resp_data;

  modport master (
    input  cmd_val, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  rf_read_data0, rf_read_data1, resp_rdy,
    output cmd_rdy, rf_read_addr0, rf_read_addr1,
    output rf_write_en, rf_write_addr, rf_write_data,
    output resp_val, resp_data
  );

  modport slave (
    output cmd_val, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output rf_read_data0, rf_read_data1, resp_rdy,
    input  cmd_rdy, rf_read_addr0, rf_read_addr1,
    input  rf_write_en, rf_write_addr, rf_write_data,
    input  resp_val, resp_data
  );

endinterface

// File: rtl/rf_cmd_alu.sv
// Combinational result unit for the X stage; all arithmetic wraps mod 2^DATA_W.
module rf_cmd_alu
  import rf_cmd_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = d0 + d1;
      OP_SUB:  result = d0 - d1;
      OP_ADDI: result = d0 + imm;
      OP_LI:   result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_cmd_initiator.sv
// Two-stage (X read/execute, W writeback/response) command front end for a 2R/1W register file.
// Define RF_CMD_INIT_EN to zero registers 1..7 in an INIT phase after reset.
module rf_cmd_initiator
  import rf_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rf_cmd_initiator_if.master bus
);

  cmd_t              x_cmd_q, x_cmd_d;
  logic              x_val_q, x_val_d;
  wb_t               w_q, w_d;
  logic              w_val_q, w_val_d;

  logic              run;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;
  logic              w_fire, x_adv, cmd_rdy, cmd_fire;
  logic [DATA_W-1:0] alu_res;

`ifdef RF_CMD_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} init_st_e;
  init_st_e          st_q, st_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // cnt_q==0 is a quiet post-reset step so no write is driven while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= ST_INIT;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (st_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(NREGS - 1)) st_d = ST_RUN;
    end
  end

  always_comb begin
    run       = (st_q == ST_RUN);
    init_wr   = (st_q == ST_INIT) && (cnt_q != '0);
    init_addr = cnt_q;
  end
`else
  assign run       = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  // X re-samples the RF every cycle it is held, so a stalled dependency resolves via RF forwarding
  assign w_fire   = w_val_q && bus.resp_rdy && run;
  assign x_adv    = x_val_q && (!w_val_q || w_fire);
  assign cmd_rdy  = run && (!x_val_q || x_adv);
  assign cmd_fire = bus.cmd_val && cmd_rdy;

  rf_cmd_alu u_alu (
    .op     (x_cmd_q.op),
    .d0     (bus.rf_read_data0),
    .d1     (bus.rf_read_data1),
    .imm    (x_cmd_q.imm),
    .result (alu_res)
  );

  always_comb begin
    x_val_d = x_val_q;
    x_cmd_d = x_cmd_q;
    w_val_d = w_val_q;
    w_d     = w_q;
    if (x_adv)  x_val_d = 1'b0;
    if (cmd_fire) begin
      x_val_d     = 1'b1;
      x_cmd_d.op  = op_e'(bus.cmd_op);
      x_cmd_d.rd  = bus.cmd_rd;
      x_cmd_d.rs1 = bus.cmd_rs1;
      x_cmd_d.rs2 = bus.cmd_rs2;
      x_cmd_d.imm = bus.cmd_imm;
    end
    if (w_fire) w_val_d = 1'b0;
    if (x_adv) begin
      w_val_d  = 1'b1;
      w_d.rd     = x_cmd_q.rd;
      w_d.result = alu_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_val_q <= 1'b0;
      x_cmd_q <= '0;
      w_val_q <= 1'b0;
      w_q     <= '0;
    end else begin
      x_val_q <= x_val_d;
      x_cmd_q <= x_cmd_d;
      w_val_q <= w_val_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    bus.cmd_rdy       = cmd_rdy;
    bus.rf_read_addr0 = x_val_q ? x_cmd_q.rs1 : '0;
    bus.rf_read_addr1 = x_val_q ? x_cmd_q.rs2 : '0;
    bus.resp_val      = w_val_q;
    bus.resp_data     = w_q.result;
    bus.rf_write_en   = init_wr || w_fire;
    bus.rf_write_addr = '0;
    bus.rf_write_data = '0;
    if (init_wr) begin
      bus.rf_write_addr = init_addr;
    end else if (w_val_q) begin
      bus.rf_write_addr = w_q.rd;
      bus.rf_write_data = w_q.result;
    end
  end

endmodule

// File: tb/tb_rf_cmd_initiator.sv
// Bench for rf_cmd_initiator: attached forwarding RF, program-order reference model, directed tables and random traffic.
module tb_rf_cmd_initiator;
  import rf_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_cmd_initiator_if bus();

  rf_cmd_initiator dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Attached register file: combinational read, same-cycle write forwarding, r0 hardwired to zero
  logic [7:0] rf [8] = '{default: 8'h00};
  assign bus.rf_read_data0 = (bus.rf_read_addr0 == 3'd0) ? 8'h00 :
    (bus.rf_write_en && bus.rf_write_addr == bus.rf_read_addr0) ? bus.rf_write_data : rf[bus.rf_read_addr0];
  assign bus.rf_read_data1 = (bus.rf_read_addr1 == 3'd0) ? 8'h00 :
    (bus.rf_write_en && bus.rf_write_addr == bus.rf_read_addr1) ? bus.rf_write_data : rf[bus.rf_read_addr1];
  always @(posedge clk) if (bus.rf_write_en && bus.rf_write_addr != 3'd0) rf[bus.rf_write_addr] <= bus.rf_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] rd; logic [7:0] data; } exp_t;
  typedef struct { logic [1:0] op; logic [2:0] rd, rs1, rs2; logic [7:0] imm; logic [7:0] exp; } vec_t;

  exp_t       exp_q[$];
  logic [7:0] cm [8] = '{default: 8'h00};
  logic [7:0] log_data[$];
  int         log_cyc[$];
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] a, b, imm);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a + imm;
      default: return imm;
    endcase
  endfunction

  // Result of each command = rule applied to architectural state after all earlier commands
  task automatic monitor();
    exp_t e;
    logic [7:0] arch [8];
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
`ifdef RF_CMD_INIT_EN
        for (int i = 0; i < 8; i++) cm[i] = 8'h00;
`endif
        continue;
      end
      if (!mon_en) continue;
      if (bus.resp_val && bus.resp_rdy) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_data", bus.resp_data, e.data);
          chk("wr_en", bus.rf_write_en, 1);
          chk("wr_addr", bus.rf_write_addr, e.rd);
          chk("wr_data", bus.rf_write_data, e.data);
          if (e.rd != 3'd0) cm[e.rd] = e.data;
          log_data.push_back(bus.resp_data);
          log_cyc.push_back(cyc);
        end
      end else begin
        chk("wr_en_idle", bus.rf_write_en, 0);
      end
      if (bus.cmd_val && bus.cmd_rdy) begin
        arch = cm;
        foreach (exp_q[i]) if (exp_q[i].rd != 3'd0) arch[exp_q[i].rd] = exp_q[i].data;
        e.rd   = bus.cmd_rd;
        e.data = ref_result(bus.cmd_op, arch[bus.cmd_rs1], arch[bus.cmd_rs2], bus.cmd_imm);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rd, rs1, rs2, input logic [7:0] imm);
    bit f = 1'b0;
    int n = 0;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    bus.cmd_val = 1'b1;
    while (!f && n < 100) begin
      @(negedge clk); f = bus.cmd_rdy;
      @(posedge clk); #1; n++;
    end
    if (!f) chk("issue_timeout", 0, 1);
    bus.cmd_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.resp_val) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic after_reset();
`ifdef RF_CMD_INIT_EN
    int k = 1;
    int n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (bus.cmd_rdy) break;
      chk("init_wen", bus.rf_write_en, 1);
      chk("init_addr", bus.rf_write_addr, k);
      chk("init_data", bus.rf_write_data, 0);
      chk("init_resp_val", bus.resp_val, 0);
      k++;
    end
    chk("init_count", k, 8);
`else
    @(negedge clk);
    chk("rdy_after_reset", bus.cmd_rdy, 1);
`endif
    @(posedge clk); #1;
  endtask

  vec_t tbl [12];
  int   base;
  logic [7:0] save6, exp6;
  bit   rdy_rst;

  initial begin
    tbl[0]  = '{2'd3, 3'd1, 3'd0, 3'd0, 8'hab, 8'hab};
    tbl[1]  = '{2'd3, 3'd1, 3'd0, 3'd0, 8'h23, 8'h23};
    tbl[2]  = '{2'd2, 3'd2, 3'd1, 3'd0, 8'h22, 8'h45};
    tbl[3]  = '{2'd3, 3'd1, 3'd0, 3'd0, 8'h01, 8'h01};
    tbl[4]  = '{2'd3, 3'd2, 3'd0, 3'd0, 8'h02, 8'h02};
    tbl[5]  = '{2'd1, 3'd3, 3'd1, 3'd2, 8'h00, 8'hff};
    tbl[6]  = '{2'd0, 3'd4, 3'd3, 3'd2, 8'h00, 8'h01};
    tbl[7]  = '{2'd3, 3'd0, 3'd0, 3'd0, 8'h55, 8'h55};
    tbl[8]  = '{2'd0, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00};
    tbl[9]  = '{2'd2, 3'd5, 3'd1, 3'd0, 8'h07, 8'h07};
    tbl[10] = '{2'd0, 3'd6, 3'd4, 3'd4, 8'h00, 8'h02};
    tbl[11] = '{2'd1, 3'd7, 3'd0, 3'd4, 8'h00, 8'hff};
`ifdef RF_CMD_INIT_EN
    rdy_rst = 1'b0;
`else
    rdy_rst = 1'b1;
`endif

    bus.cmd_val = 0; bus.cmd_op = 0; bus.cmd_rd = 0; bus.cmd_rs1 = 0; bus.cmd_rs2 = 0; bus.cmd_imm = 0;
    bus.resp_rdy = 0;
    fork monitor(); join_none

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_rdy", bus.cmd_rdy, rdy_rst);
    chk("rst_resp_val", bus.resp_val, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_wen", bus.rf_write_en, 0);
    chk("rst_waddr", bus.rf_write_addr, 0);
    chk("rst_wdata", bus.rf_write_data, 0);
    chk("rst_raddr0", bus.rf_read_addr0, 0);
    chk("rst_raddr1", bus.rf_read_addr1, 0);
    rst_n = 1'b1;
    after_reset();
    mon_en = 1'b1;

    // first-command latency: response in the second cycle after acceptance
    bus.resp_rdy = 1'b1;
    issue(2'd3, 3'd1, 3'd3, 3'd5, 8'hab);
    @(negedge clk);
    chk("lat_x_resp_val", bus.resp_val, 0);
    chk("lat_x_raddr0", bus.rf_read_addr0, 3);
    chk("lat_x_raddr1", bus.rf_read_addr1, 5);
    @(negedge clk);
    chk("lat_w_resp_val", bus.resp_val, 1);
    chk("lat_w_resp_data", bus.resp_data, 8'hab);
    chk("lat_w_wen", bus.rf_write_en, 1);
    chk("lat_w_waddr", bus.rf_write_addr, 1);
    chk("lat_w_wdata", bus.rf_write_data, 8'hab);
    @(posedge clk); #1;
    drain();

    // directed table, back to back
    base = log_data.size();
    for (int i = 0; i < 12; i++) issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
    drain();
    chk("tbl_count", log_data.size() - base, 12);
    if (log_data.size() - base == 12)
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("tbl_data[%0d]", i), log_data[base+i], tbl[i].exp);
        chk($sformatf("tbl_cyc[%0d]", i), log_cyc[base+i] - log_cyc[base], i);
      end
    chk("rf_r1_zero", rf[1], 8'h00);
    chk("rf_r0_zero", rf[0], 8'h00);

    // backpressure: two accepted, third waits
    bus.resp_rdy = 1'b0;
    base = log_data.size();
    issue(2'd3, 3'd2, 3'd0, 3'd0, 8'h11);
    issue(2'd3, 3'd3, 3'd0, 3'd0, 8'h22);
    bus.cmd_op = 2'd0; bus.cmd_rd = 3'd4; bus.cmd_rs1 = 3'd2; bus.cmd_rs2 = 3'd3; bus.cmd_imm = 8'h00;
    bus.cmd_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_cmd_rdy", bus.cmd_rdy, 0);
      chk("bp_wen", bus.rf_write_en, 0);
      chk("bp_resp_val", bus.resp_val, 1);
      chk("bp_resp_data", bus.resp_data, 8'h11);
    end
    @(posedge clk); #1;
    bus.resp_rdy = 1'b1;
    issue(2'd0, 3'd4, 3'd2, 3'd3, 8'h00);
    drain();
    chk("bp_count", log_data.size() - base, 3);
    if (log_data.size() - base == 3) begin
      chk("bp_r0", log_data[base], 8'h11);
      chk("bp_r1", log_data[base+1], 8'h22);
      chk("bp_r2", log_data[base+2], 8'h33);
      chk("bp_consec", log_cyc[base+2] - log_cyc[base], 2);
    end

    // random traffic, checked by the reference model
    for (int i = 0; i < 400; i++) begin
      bus.cmd_val  = ($urandom_range(0, 3) != 0);
      bus.cmd_op   = 2'($urandom_range(0, 3));
      bus.cmd_rd   = 3'($urandom_range(0, 7));
      bus.cmd_rs1  = 3'($urandom_range(0, 7));
      bus.cmd_rs2  = 3'($urandom_range(0, 7));
      bus.cmd_imm  = 8'($urandom);
      bus.resp_rdy = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    bus.cmd_val = 1'b0;
    bus.resp_rdy = 1'b1;
    drain();

    // reset with X and W both full
    bus.resp_rdy = 1'b0;
    save6 = rf[6];
    issue(2'd3, 3'd6, 3'd0, 3'd0, 8'hee);
    issue(2'd3, 3'd6, 3'd0, 3'd0, 8'hdd);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_val", bus.resp_val, 0);
    chk("mid_rst_wen", bus.rf_write_en, 0);
    chk("mid_rst_cmd_rdy", bus.cmd_rdy, rdy_rst);
    mon_en = 1'b0;
    bus.resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    after_reset();
    mon_en = 1'b1;
`ifdef RF_CMD_INIT_EN
    exp6 = 8'h00;
`else
    exp6 = save6;
`endif
    chk("mid_rst_no_write", rf[6], exp6);
    base = log_data.size();
    issue(2'd3, 3'd1, 3'd0, 3'd0, 8'h5a);
    issue(2'd0, 3'd2, 3'd1, 3'd1, 8'h00);
    drain();
    chk("post_rst_count", log_data.size() - base, 2);
    if (log_data.size() - base == 2) chk("post_rst_add", log_data[base+1], 8'hb4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
